// File: rtl/id_stage_param_pkg.sv
// Shared decode-stage definitions: control-word layout, source encodings,
// fixed register indices and the forwarding-source selector.
package id_stage_param_pkg;

    localparam int INST_W = 16;
    localparam int SIG_W  = 6;

    // Layout of the control word: {SRC1[1:0], SRC2, RegDst, ExtOp, ExtPlace}
    localparam int SIG_SRC1_LO  = 4;
    localparam int SIG_SRC2     = 3;
    localparam int SIG_REGDST   = 2;
    localparam int SIG_EXTOP    = 1;
    localparam int SIG_EXTPLACE = 0;

    localparam int R0_IDX       = 0;
    localparam int R7_IDX       = 7;
    localparam int LINK_REG_DEF = 7;

    typedef enum logic [1:0] {
        SRC1_INST = 2'b00,
        SRC1_ZERO = 2'b01,
        SRC1_R7   = 2'b10,
        SRC1_RSVD = 2'b11
    } src1_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_EXE = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/id_stage_param_if.sv
// Decode-stage bus: IF/ID inputs, later-stage tags/data, and the ID/EX outputs.
interface id_stage_param_if
    import id_stage_param_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3
) ();

    logic [INST_W-1:0]     inst_id;
    logic [DATA_W-1:0]     pc_id;
    logic                  valid_id;
    logic [SIG_W-1:0]      signals;
    logic                  uses_a;
    logic                  uses_b;
    logic                  exe_wr;
    logic                  exe_is_load;
    logic [REG_ADDR_W-1:0] exe_dest;
    logic [DATA_W-1:0]     exe_result;
    logic                  mem_wr;
    logic [REG_ADDR_W-1:0] mem_dest;
    logic [DATA_W-1:0]     mem_data;
    logic                  wb_en;
    logic [REG_ADDR_W-1:0] wb_dest;
    logic [DATA_W-1:0]     wb_data;
    logic                  flush;

    logic                  stall_id;
    logic                  ex_valid;
    logic [DATA_W-1:0]     ex_a;
    logic [DATA_W-1:0]     ex_b;
    logic [DATA_W-1:0]     ex_imm;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic [DATA_W-1:0]     ex_br_target;
    logic [DATA_W-1:0]     ex_j_target;
    logic                  ex_gt;
    logic                  ex_lt;
    logic                  ex_eq;

    modport master (
        output inst_id, pc_id, valid_id, signals, uses_a, uses_b,
               exe_wr, exe_is_load, exe_dest, exe_result,
               mem_wr, mem_dest, mem_data, wb_en, wb_dest, wb_data, flush,
        input  stall_id, ex_valid, ex_a, ex_b, ex_imm, ex_rd,
               ex_br_target, ex_j_target, ex_gt, ex_lt, ex_eq
    );

    modport slave (
        input  inst_id, pc_id, valid_id, signals, uses_a, uses_b,
               exe_wr, exe_is_load, exe_dest, exe_result,
               mem_wr, mem_dest, mem_data, wb_en, wb_dest, wb_data, flush,
        output stall_id, ex_valid, ex_a, ex_b, ex_imm, ex_rd,
               ex_br_target, ex_j_target, ex_gt, ex_lt, ex_eq
    );

endinterface

// File: rtl/id_stage_param_regfile_2r1w.sv
// Register file with two combinational read ports and one clocked write port.
// R0 is hard-wired to zero; a same-cycle write is visible on the read ports.
module id_stage_param_regfile_2r1w #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] rd_addr_a,
    input  logic [REG_ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0]     rd_data_a,
    output logic [DATA_W-1:0]     rd_data_b,
    input  logic                  wr_en,
    input  logic [REG_ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0]     wr_data
);

    localparam int NUM_REGS = 2 ** REG_ADDR_W;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              wr_live;

    assign wr_live = wr_en && (wr_addr != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_live) begin
            regs[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_a = regs[rd_addr_a];
        rd_data_b = regs[rd_addr_b];
        if (wr_live && (wr_addr == rd_addr_a)) rd_data_a = wr_data;
        if (wr_live && (wr_addr == rd_addr_b)) rd_data_b = wr_data;
        if (rd_addr_a == '0) rd_data_a = '0;
        if (rd_addr_b == '0) rd_data_b = '0;
    end

endmodule

// File: rtl/id_stage_param.sv
// Decode stage: register read with internal forwarding, load-use stall,
// immediate/target generation, signed compare, and the ID/EX register.
module id_stage_param
    import id_stage_param_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3,
    parameter int IMM_W      = 8,
    parameter int LINK_REG   = LINK_REG_DEF
) (
    input logic        clk,
    input logic        reset,
    id_stage_param_if.slave bus
);

    src1_e                    src1_p0;
    logic [REG_ADDR_W-1:0]    ra_p0;
    logic [REG_ADDR_W-1:0]    rb_p0;
    logic [REG_ADDR_W-1:0]    rd_p0;
    logic [DATA_W-1:0]        rf_a_p0;
    logic [DATA_W-1:0]        rf_b_p0;
    fwd_sel_e                 sel_a_p0;
    fwd_sel_e                 sel_b_p0;
    logic [DATA_W-1:0]        op_a_p0;
    logic [DATA_W-1:0]        op_b_p0;
    logic signed [DATA_W-1:0] cmp_a_p0;
    logic signed [DATA_W-1:0] cmp_b_p0;
    logic [DATA_W-1:0]        imm_p0;
    logic                     stall_p0;
    logic                     unused_inst;

    logic                     vld_p1;
    logic [DATA_W-1:0]        a_p1;
    logic [DATA_W-1:0]        b_p1;
    logic [DATA_W-1:0]        imm_p1;
    logic [REG_ADDR_W-1:0]    rd_p1;
    logic [DATA_W-1:0]        br_p1;
    logic [DATA_W-1:0]        j_p1;
    logic                     gt_p1;
    logic                     lt_p1;
    logic                     eq_p1;

    function automatic fwd_sel_e pick_fwd(
        input logic [REG_ADDR_W-1:0] idx,
        input logic                  exe_wr,
        input logic                  exe_is_load,
        input logic [REG_ADDR_W-1:0] exe_dest,
        input logic                  mem_wr,
        input logic [REG_ADDR_W-1:0] mem_dest
    );
        if (idx == '0) return FWD_RF;
        if (exe_wr && !exe_is_load && (exe_dest == idx)) return FWD_EXE;
        if (mem_wr && (mem_dest == idx)) return FWD_MEM;
        return FWD_RF;
    endfunction

    function automatic logic [DATA_W-1:0] extend_imm(
        input logic [IMM_W-1:0] imm,
        input logic             ext_op,
        input logic             ext_place
    );
        if (ext_place) return {imm, {(DATA_W-IMM_W){1'b0}}};
        if (ext_op)    return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
        return {{(DATA_W-IMM_W){1'b0}}, imm};
    endfunction

    // ---- Stage p0: decode, register read, forwarding, hazard ----
    assign src1_p0 = src1_e'(bus.signals[SIG_SRC1_LO +: 2]);

    always_comb begin
        ra_p0 = '0;
        case (src1_p0)
            SRC1_INST: ra_p0 = bus.inst_id[6 +: REG_ADDR_W];
            SRC1_R7:   ra_p0 = REG_ADDR_W'(R7_IDX);
            default:   ra_p0 = REG_ADDR_W'(R0_IDX);
        endcase
    end

    assign rb_p0 = bus.signals[SIG_SRC2]   ? bus.inst_id[3 +: REG_ADDR_W]
                                           : bus.inst_id[9 +: REG_ADDR_W];
    assign rd_p0 = bus.signals[SIG_REGDST] ? REG_ADDR_W'(LINK_REG)
                                           : bus.inst_id[9 +: REG_ADDR_W];

    id_stage_param_regfile_2r1w #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_regfile (
        .clk       (clk),
        .reset     (reset),
        .rd_addr_a (ra_p0),
        .rd_addr_b (rb_p0),
        .rd_data_a (rf_a_p0),
        .rd_data_b (rf_b_p0),
        .wr_en     (bus.wb_en),
        .wr_addr   (bus.wb_dest),
        .wr_data   (bus.wb_data)
    );

    assign sel_a_p0 = pick_fwd(ra_p0, bus.exe_wr, bus.exe_is_load, bus.exe_dest,
                               bus.mem_wr, bus.mem_dest);
    assign sel_b_p0 = pick_fwd(rb_p0, bus.exe_wr, bus.exe_is_load, bus.exe_dest,
                               bus.mem_wr, bus.mem_dest);

    always_comb begin
        op_a_p0 = rf_a_p0;
        op_b_p0 = rf_b_p0;
        case (sel_a_p0)
            FWD_EXE: op_a_p0 = bus.exe_result;
            FWD_MEM: op_a_p0 = bus.mem_data;
            default: op_a_p0 = rf_a_p0;
        endcase
        case (sel_b_p0)
            FWD_EXE: op_b_p0 = bus.exe_result;
            FWD_MEM: op_b_p0 = bus.mem_data;
            default: op_b_p0 = rf_b_p0;
        endcase
    end

    assign cmp_a_p0 = op_a_p0;
    assign cmp_b_p0 = op_b_p0;

    // A load in EXE cannot be forwarded yet; hold decode one cycle until it reaches MEM.
    assign stall_p0 = bus.valid_id && bus.exe_wr && bus.exe_is_load &&
                      (bus.exe_dest != '0) &&
                      ((bus.uses_a && (ra_p0 == bus.exe_dest)) ||
                       (bus.uses_b && (rb_p0 == bus.exe_dest)));

    assign imm_p0 = extend_imm(bus.inst_id[IMM_W-1:0], bus.signals[SIG_EXTOP],
                               bus.signals[SIG_EXTPLACE]);

    assign unused_inst = ^bus.inst_id[INST_W-1:12];

    // ---- Stage p1: ID/EX register ----
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1 <= 1'b0;
            a_p1   <= '0;
            b_p1   <= '0;
            imm_p1 <= '0;
            rd_p1  <= '0;
            br_p1  <= '0;
            j_p1   <= '0;
            gt_p1  <= 1'b0;
            lt_p1  <= 1'b0;
            eq_p1  <= 1'b0;
        end else if (bus.flush || stall_p0) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= bus.valid_id;
            a_p1   <= op_a_p0;
            b_p1   <= op_b_p0;
            imm_p1 <= imm_p0;
            rd_p1  <= rd_p0;
            br_p1  <= bus.pc_id + imm_p0;
            j_p1   <= {bus.pc_id[DATA_W-1:12], bus.inst_id[11:0]};
            gt_p1  <= cmp_a_p0 >  cmp_b_p0;
            lt_p1  <= cmp_a_p0 <  cmp_b_p0;
            eq_p1  <= cmp_a_p0 == cmp_b_p0;
        end
    end

    assign bus.stall_id     = stall_p0;
    assign bus.ex_valid     = vld_p1;
    assign bus.ex_a         = a_p1;
    assign bus.ex_b         = b_p1;
    assign bus.ex_imm       = imm_p1;
    assign bus.ex_rd        = rd_p1;
    assign bus.ex_br_target = br_p1;
    assign bus.ex_j_target  = j_p1;
    assign bus.ex_gt        = gt_p1;
    assign bus.ex_lt        = lt_p1;
    assign bus.ex_eq        = eq_p1;

endmodule

// File: tb/tb_id_stage_param.sv
// Directed bench for id_stage_param: forwarding, load-use bubble, flush,
// immediates/targets, signed compare and reset.
module tb_id_stage_param;

    logic clk = 1'b0;
    logic reset;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    id_stage_param_if #(.DATA_W(16), .REG_ADDR_W(3)) bus ();

    id_stage_param #(
        .DATA_W     (16),
        .REG_ADDR_W (3),
        .IMM_W      (8),
        .LINK_REG   (7)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.inst_id     = '0;
        bus.pc_id       = '0;
        bus.valid_id    = 1'b0;
        bus.signals     = '0;
        bus.uses_a      = 1'b0;
        bus.uses_b      = 1'b0;
        bus.exe_wr      = 1'b0;
        bus.exe_is_load = 1'b0;
        bus.exe_dest    = '0;
        bus.exe_result  = '0;
        bus.mem_wr      = 1'b0;
        bus.mem_dest    = '0;
        bus.mem_data    = '0;
        bus.wb_en       = 1'b0;
        bus.wb_dest     = '0;
        bus.wb_data     = '0;
        bus.flush       = 1'b0;
    endtask

    task automatic decode(input logic [15:0] inst, input logic [5:0] sig, input logic [15:0] pc);
        bus.inst_id  = inst;
        bus.signals  = sig;
        bus.pc_id    = pc;
        bus.valid_id = 1'b1;
        bus.uses_a   = 1'b1;
        bus.uses_b   = 1'b1;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        tick();
        tick();
        check("reset_valid", bus.ex_valid, 0);
        check("reset_a",     bus.ex_a, 0);
        check("reset_imm",   bus.ex_imm, 0);
        check("reset_flags", {bus.ex_gt, bus.ex_lt, bus.ex_eq}, 0);

        // Write-through of R3 in the same cycle it is read
        reset = 1'b0;
        idle();
        decode(16'h00C0, 6'b000000, 16'h0100);
        bus.wb_en = 1'b1; bus.wb_dest = 3'd3; bus.wb_data = 16'h1234;
        tick();
        check("wt_a",     bus.ex_a, 16'h1234);
        check("wt_valid", bus.ex_valid, 1);
        check("wt_imm",   bus.ex_imm, 16'h00C0);
        check("wt_br",    bus.ex_br_target, 16'h01C0);
        check("wt_gt",    {bus.ex_gt, bus.ex_lt, bus.ex_eq}, 3'b100);
        idle();
        decode(16'h00C0, 6'b000000, 16'h0100);
        tick();
        check("rf_r3", bus.ex_a, 16'h1234);

        // EXE beats MEM, then MEM when EXE drops out
        idle();
        decode(16'h0010, 6'b001000, 16'h0000);
        bus.exe_wr = 1'b1; bus.exe_dest = 3'd2; bus.exe_result = 16'h0008;
        bus.mem_wr = 1'b1; bus.mem_dest = 3'd2; bus.mem_data   = 16'h0010;
        tick();
        check("fwd_exe_b", bus.ex_b, 16'h0008);
        check("fwd_lt",    {bus.ex_gt, bus.ex_lt, bus.ex_eq}, 3'b010);
        bus.exe_wr = 1'b0;
        tick();
        check("fwd_mem_b", bus.ex_b, 16'h0010);

        // Load-use: one bubble, then forward from MEM
        idle();
        decode(16'h0100, 6'b000000, 16'h0000);
        bus.uses_b = 1'b0;
        bus.exe_wr = 1'b1; bus.exe_is_load = 1'b1; bus.exe_dest = 3'd4;
        #1;
        check("lu_stall", bus.stall_id, 1);
        tick();
        check("lu_bubble", bus.ex_valid, 0);
        check("lu_hold_b", bus.ex_b, 16'h0010);
        bus.exe_wr = 1'b0; bus.exe_is_load = 1'b0; bus.exe_dest = 3'd0;
        bus.mem_wr = 1'b1; bus.mem_dest = 3'd4; bus.mem_data = 16'h00AA;
        #1;
        check("lu_nostall", bus.stall_id, 0);
        tick();
        check("lu_a",     bus.ex_a, 16'h00AA);
        check("lu_valid", bus.ex_valid, 1);

        // Flush during stall, then R0 write attempts
        idle();
        decode(16'h0100, 6'b000000, 16'h0000);
        bus.exe_wr = 1'b1; bus.exe_is_load = 1'b1; bus.exe_dest = 3'd4;
        bus.flush = 1'b1;
        #1;
        check("fl_stall", bus.stall_id, 1);
        tick();
        check("fl_valid", bus.ex_valid, 0);
        idle();
        decode(16'h0000, 6'b000000, 16'h0000);
        bus.wb_en = 1'b1; bus.wb_dest = 3'd0; bus.wb_data = 16'hFFFF;
        tick();
        check("r0_wt", bus.ex_a, 0);
        idle();
        decode(16'h0000, 6'b000000, 16'h0000);
        tick();
        check("r0_read", bus.ex_a, 0);

        // Immediate placement and targets
        idle();
        decode(16'h0080, 6'b000010, 16'hFFFE);
        tick();
        check("imm_sext", bus.ex_imm, 16'hFF80);
        check("br_wrap",  bus.ex_br_target, 16'hFF7E);
        check("j_tgt",    bus.ex_j_target, 16'hF080);
        decode(16'h0080, 6'b000011, 16'hFFFE);
        tick();
        check("imm_high", bus.ex_imm, 16'h8000);
        check("br_high",  bus.ex_br_target, 16'h7FFE);
        decode(16'h0080, 6'b000000, 16'hFFFE);
        tick();
        check("imm_zext", bus.ex_imm, 16'h0080);
        check("br_zext",  bus.ex_br_target, 16'h007E);
        decode(16'h0A00, 6'b000100, 16'h0000);
        tick();
        check("rd_link", bus.ex_rd, 7);
        decode(16'h0A00, 6'b000000, 16'h0000);
        tick();
        check("rd_inst", bus.ex_rd, 5);

        // Source-A selection and signed compare
        idle();
        decode(16'h01C0, 6'b100000, 16'h0000);
        bus.mem_wr = 1'b1; bus.mem_dest = 3'd7; bus.mem_data = 16'h0777;
        tick();
        check("src1_r7", bus.ex_a, 16'h0777);
        bus.mem_dest = 3'd7;
        decode(16'h01C0, 6'b010000, 16'h0000);
        bus.exe_wr = 1'b1; bus.exe_dest = 3'd0; bus.exe_result = 16'h5A5A;
        tick();
        check("src1_zero", bus.ex_a, 0);
        idle();
        decode(16'h0050, 6'b001000, 16'h0000);
        bus.exe_wr = 1'b1; bus.exe_dest = 3'd1; bus.exe_result = 16'hFFFF;
        bus.mem_wr = 1'b1; bus.mem_dest = 3'd2; bus.mem_data   = 16'h0001;
        tick();
        check("cmp_a",  bus.ex_a, 16'hFFFF);
        check("cmp_lt", {bus.ex_gt, bus.ex_lt, bus.ex_eq}, 3'b010);
        decode(16'h0048, 6'b001000, 16'h0000);
        tick();
        check("cmp_eq", {bus.ex_gt, bus.ex_lt, bus.ex_eq}, 3'b001);

        // Reset clears the ID/EX register and the register file
        idle();
        bus.wb_en = 1'b1; bus.wb_dest = 3'd5; bus.wb_data = 16'h5555;
        tick();
        idle();
        decode(16'h0140, 6'b000000, 16'h0000);
        tick();
        check("r5_written", bus.ex_a, 16'h5555);
        idle();
        reset = 1'b1;
        tick();
        check("rst_valid", bus.ex_valid, 0);
        check("rst_a",     bus.ex_a, 0);
        check("rst_tgts",  {bus.ex_br_target, bus.ex_j_target}, 0);
        reset = 1'b0;
        decode(16'h0140, 6'b000000, 16'h0000);
        tick();
        check("rst_r5",    bus.ex_a, 0);
        check("rst_r5_vld", bus.ex_valid, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/id_stage_param.md
Name: id_stage_param

Overview:
Parametrised decode stage for the pipelined processor. Contains the register file, forwarding-source selection, load-use hazard detection, immediate/target generation and branch compare. Ends in a registered ID/EX pipeline boundary with stall and flush control. Sits between the IF/ID register and the EXE stage.
- New relative to the previous decode stage: forwarding is decided internally from destination tags rather than by external mux selects.
- The ID/EX register is owned by this block.

Parameters:
DATA_W, 16, datapath/register width
REG_ADDR_W, 3, register index width (NUM_REGS = 2**REG_ADDR_W)
IMM_W, 8, raw immediate field width (inst[IMM_W-1:0])
LINK_REG, 7, index written by call/link instructions (RegDst=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
inst_id  in  16  instruction from IF/ID
pc_id  in  DATA_W  PC of inst_id
valid_id  in  1  inst_id is a real instruction
signals  in  6  {SRC1[1:0], SRC2, RegDst, ExtOp, ExtPlace}
uses_a / uses_b  in  1 each  instruction reads source A / source B
exe_wr, exe_is_load  in  1 each  EXE-stage instruction writes a register / is a load
exe_dest  in  REG_ADDR_W  EXE-stage destination
exe_result  in  DATA_W  EXE ALU result
mem_wr  in  1  MEM-stage instruction writes
mem_dest  in  REG_ADDR_W  MEM destination
mem_data  in  DATA_W  MEM write-back value
wb_en  in  1  register-file write enable
wb_dest  in  REG_ADDR_W  write address
wb_data  in  DATA_W  write data
flush  in  1  squash the instruction entering ID/EX
stall_id  out  1  freeze PC and IF/ID (combinational)
ex_valid  out  1  ID/EX holds a real instruction
ex_a, ex_b, ex_imm  out  DATA_W each  operands and extended immediate
ex_rd  out  REG_ADDR_W  destination register
ex_br_target, ex_j_target  out  DATA_W each  pc+imm; {pc[DATA_W-1:12], inst[11:0]}
ex_gt, ex_lt, ex_eq  out  1 each  signed compare of forwarded A vs B

Behaviour:
- Reset: all ex_* outputs 0, ex_valid 0, every register-file entry 0. A reset mid-stall clears the stall state.

Register file:
- Two combinational read ports, one write port at posedge clk when wb_en.
- Writes to R0 are ignored; R0 reads 0.
- Write-through: if wb_en and wb_dest matches a read address, that read returns wb_data in the same cycle.

Source selection:
- Ra = inst[8:6] / 0 / 7 for SRC1 = 00 / 01 / 10; SRC1 = 11 gives Ra = 0.
- Rb = SRC2 ? inst[5:3] : inst[11:9].
- Rd = RegDst ? LINK_REG : inst[11:9].

Forwarding (per operand, register index ≠ 0), priority order:
1. EXE: exe_wr and exe_dest matches and not exe_is_load.
2. MEM: mem_wr and mem_dest matches.
3. Register file (which includes the WB write-through).

Load-use hazard:
- stall_id = valid_id & exe_wr & exe_is_load & ((uses_a & Ra == exe_dest) | (uses_b & Rb == exe_dest)), with exe_dest ≠ 0.
- On the next edge a bubble is inserted: ex_valid = 0, other ex_* hold.
- The next cycle, the load is in MEM and is forwarded from mem_data.
- Exactly one bubble per load-use.

Immediate extension:
- ExtPlace = 0: low placement. Sign-extend if ExtOp, else zero-extend.
- ExtPlace = 1: imm << (DATA_W - IMM_W), low bits zero.
- ex_br_target wraps modulo 2**DATA_W.

ID/EX register update at posedge clk, first matching rule wins:
1. reset → clear.
2. flush → ex_valid 0 (flush beats stall).
3. stall_id → bubble.
4. Otherwise → load all fields, ex_valid = valid_id.

Latency: one cycle from inst_id to ex_*.

Decomposition:
- Shared package: SRC1 encodings, signal bit positions, R0/LINK_REG constants, forward-select enum {FWD_RF, FWD_MEM, FWD_EXE}.
- One sub-module: regfile_2r1w, parametrised by DATA_W and REG_ADDR_W, including R0-zero and write-through.

Test Plan:
- Write-through: wb_en=1, wb_dest=3, wb_data=0x1234; decode inst reading R3 (SRC1=00, inst[8:6]=3) in the same cycle → ex_a=0x1234 next cycle.
- Forward priority: exe_dest=mem_dest=2, exe_result=0x0008, mem_data=0x0010, Rb=2 → ex_b=0x0008. Drop exe_wr → ex_b=0x0010.
- Load-use: exe_is_load=1, exe_dest=4, Ra=4 → stall_id=1, one bubble (ex_valid=0). Following cycle with mem_data=0x00AA → ex_a=0x00AA, ex_valid=1.
- Flush during stall: stall_id=1 and flush=1 → ex_valid=0. R0 write wb_data=0xFFFF → a later read of R0 gives 0.
- Immediate/targets: pc=0xFFFE, imm=0x80, ExtOp=1, ExtPlace=0 → ex_imm=0xFF80, ex_br_target=0xFF7E. ExtPlace=1 → ex_imm=0x8000.
- Compare and reset: A=0xFFFF, B=0x0001 → ex_lt=1, ex_gt=0, ex_eq=0. Assert reset for one cycle → all ex_* 0, and a subsequent read of R5 returns 0.
